cs_req_arbiter: RTL and testbench

- Multi-requester front end for the 256x16 computational storage array.
- Accepts RD/WR/ADD/SUB requests from NUM_REQ clients over valid/ready handshakes.
- Arbitrates round-robin and sequences exactly one command at a time onto the storage command/address/DQ bus.
- Returns read data and completion pulses to the issuing client; owns the tri-state DQ bus toward the array.

---
 rtl/cs_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cs_req_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cs_req_arbiter.sv
// Round-robin front end for the computational storage array: accepts one client
// request at a time, issues it on the storage bus for one cycle, then returns a completion.
module cs_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_cmd,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addA,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addB,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addC,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic [1:0]                cs_cmd,
    output logic [ADDR_W-1:0]         cs_addA,
    output logic [ADDR_W-1:0]         cs_addB,
    output logic [ADDR_W-1:0]         cs_addC,
    inout  wire  [DATA_W-1:0]         cs_dq
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] CMD_RD = 2'b00;
    localparam logic [1:0] CMD_WR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
        f_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t                r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_dq_oe;
    logic [1:0]            r_cs_cmd;
    logic [ADDR_W-1:0]     r_cs_addA;
    logic [ADDR_W-1:0]     r_cs_addB;
    logic [ADDR_W-1:0]     r_cs_addC;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_busy;

    logic                  w_found;
    logic [PTR_W-1:0]      w_winner;
    logic [1:0]            w_cmd_arr   [NUM_REQ];
    logic [ADDR_W-1:0]     w_addA_arr  [NUM_REQ];
    logic [ADDR_W-1:0]     w_addB_arr  [NUM_REQ];
    logic [ADDR_W-1:0]     w_addC_arr  [NUM_REQ];
    logic [DATA_W-1:0]     w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_cmd_arr[g]   = req_cmd[g*2 +: 2];
        assign w_addA_arr[g]  = req_addA[g*ADDR_W +: ADDR_W];
        assign w_addB_arr[g]  = req_addB[g*ADDR_W +: ADDR_W];
        assign w_addC_arr[g]  = req_addC[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: scan from farthest to nearest so the nearest valid after r_rr_ptr wins.
    always_comb begin
        logic [PTR_W:0]   v_sum;
        logic [PTR_W-1:0] v_ptr;
        w_found  = 1'b0;
        w_winner = {PTR_W{1'b0}};
        v_sum    = {(PTR_W+1){1'b0}};
        v_ptr    = {PTR_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_sum    = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            v_sum    = (v_sum >= (PTR_W+1)'(NUM_REQ)) ? v_sum - (PTR_W+1)'(NUM_REQ) : v_sum;
            v_ptr    = v_sum[PTR_W-1:0];
            w_found  = w_found | req_valid[v_ptr];
            w_winner = req_valid[v_ptr] ? v_ptr : w_winner;
        end
    end

    assign req_ready = ((r_state == ST_IDLE) && w_found) ? f_onehot(w_winner) : {NUM_REQ{1'b0}};
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;
    assign cs_cmd    = r_cs_cmd;
    assign cs_addA   = r_cs_addA;
    assign cs_addB   = r_cs_addB;
    assign cs_addC   = r_cs_addC;
    // Only a WR in ISSUE drives the bus; everywhere else the array owns it.
    assign cs_dq     = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

    // Sequencer FSM with registered storage-bus and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
            r_owner     <= {PTR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_dq_oe     <= 1'b0;
            r_cs_cmd    <= CMD_RD;
            r_cs_addA   <= {ADDR_W{1'b0}};
            r_cs_addB   <= {ADDR_W{1'b0}};
            r_cs_addC   <= {ADDR_W{1'b0}};
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_winner;
                        r_rr_ptr  <= w_winner;
                        r_wdata   <= w_wdata_arr[w_winner];
                        r_dq_oe   <= (w_cmd_arr[w_winner] == CMD_WR);
                        r_cs_cmd  <= w_cmd_arr[w_winner];
                        r_cs_addA <= w_addA_arr[w_winner];
                        r_cs_addB <= w_addB_arr[w_winner];
                        r_cs_addC <= w_addC_arr[w_winner];
                        r_busy    <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // The array commits on this edge; RD data is captured on the same edge.
                    r_rsp_valid <= f_onehot(r_owner);
                    r_rsp_rdata <= (r_cs_cmd == CMD_RD) ? cs_dq : {DATA_W{1'b0}};
                    r_dq_oe     <= 1'b0;
                    r_cs_cmd    <= CMD_RD;
                    r_cs_addA   <= {ADDR_W{1'b0}};
                    r_cs_addB   <= {ADDR_W{1'b0}};
                    r_cs_addC   <= {ADDR_W{1'b0}};
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= {NUM_REQ{1'b0}};
                    r_rsp_rdata <= {DATA_W{1'b0}};
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_rsp_valid <= {NUM_REQ{1'b0}};
                    r_rsp_rdata <= {DATA_W{1'b0}};
                    r_dq_oe     <= 1'b0;
                    r_cs_cmd    <= CMD_RD;
                    r_cs_addA   <= {ADDR_W{1'b0}};
                    r_cs_addB   <= {ADDR_W{1'b0}};
                    r_cs_addC   <= {ADDR_W{1'b0}};
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs_req_arbiter.sv
// Directed bench for cs_req_arbiter with a behavioural 256x16 array on the storage bus.
module tb_cs_req_arbiter;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, ADD = 2'b10, SUB = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_addA, req_addB, req_addC;
    logic [63:0] req_wdata;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [1:0]  cs_cmd;
    logic [7:0]  cs_addA, cs_addB, cs_addC;
    wire  [15:0] cs_dq;

    logic [15:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;

    cs_req_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addA(req_addA), .req_addB(req_addB), .req_addC(req_addC),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .cs_cmd(cs_cmd), .cs_addA(cs_addA), .cs_addB(cs_addB),
        .cs_addC(cs_addC), .cs_dq(cs_dq)
    );

    always #5 clk = ~clk;

    // Array model: drives the bus for every non-WR command, commits on the rising edge.
    assign cs_dq = (cs_cmd != WR) ? mem[cs_addA] : 16'hzzzz;

    always @(posedge clk) begin
        case (cs_cmd)
            WR:      mem[cs_addC] <= cs_dq;
            ADD:     mem[cs_addC] <= mem[cs_addA] + mem[cs_addB];
            SUB:     mem[cs_addC] <= mem[cs_addA] - mem[cs_addB];
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        logic [3:0] v;
        v = 4'b0001;
        return v << c;
    endfunction

    // Bus monitor: no unknowns, and the controller drives only while a WR is in ISSUE.
    always @(negedge clk) begin
        check("dq_known", {31'd0, ((^cs_dq) !== 1'bx)}, 32'd1);
        if (cs_cmd == WR)
            check("wr_only_in_issue", {30'd0, busy, |rsp_valid}, 32'd2);
        else
            check("dq_array_owned", {16'd0, cs_dq}, {16'd0, mem[cs_addA]});
    end

    // One full transaction from client c; returns at the RESP-cycle falling edge.
    task automatic do_req(input int c, input logic [1:0] cmd, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] d,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
        int waits;
        @(negedge clk);
        req_valid[c]          = 1'b1;
        req_cmd[c*2 +: 2]     = cmd;
        req_addA[c*8 +: 8]    = a;
        req_addB[c*8 +: 8]    = b;
        req_addC[c*8 +: 8]    = d;
        req_wdata[c*16 +: 16] = wd;
        #1;
        waits = 0;
        while (!req_ready[c] && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("grant_onehot", {28'd0, req_ready}, {28'd0, onehot(c)});
        check("grant_wait", waits, 32'd0);
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
        @(negedge clk);
        check("issue_cmd", {30'd0, cs_cmd}, {30'd0, cmd});
        check("issue_addr", {8'd0, cs_addA, cs_addB, cs_addC}, {8'd0, a, b, d});
        check("issue_busy_rsp", {27'd0, busy, rsp_valid}, 32'h10);
        check("issue_no_ready", {28'd0, req_ready}, 32'd0);
        if (cmd == WR)
            check("issue_dq", {16'd0, cs_dq}, {16'd0, wd});
        @(negedge clk);
        check("resp_valid", {28'd0, rsp_valid}, {28'd0, onehot(c)});
        check("resp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rd});
        check("resp_busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b0;
        req_valid = 4'h0; req_cmd = 8'h00;
        req_addA = 32'h0; req_addB = 32'h0; req_addC = 32'h0; req_wdata = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp", {12'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus", {6'd0, cs_cmd, cs_addA, cs_addB, cs_addC}, 32'd0);

        // All four clients request from reset: grants rotate 0,1,2,3,0,1,2,3.
        reset = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", {28'd0, req_ready}, {28'd0, onehot(k % 4)});
            @(negedge clk);
            check("rr_issue_rsp", {28'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            check("rr_resp", {28'd0, rsp_valid}, {28'd0, onehot(k % 4)});
            check("rr_rdata", {16'd0, rsp_rdata}, 32'd0);
            @(negedge clk);
        end
        req_valid = 4'h0;

        do_req(0, WR, 8'h00, 8'h00, 8'h10, 16'h1234, 16'h0000);
        do_req(0, RD, 8'h10, 8'h00, 8'h00, 16'h0000, 16'h1234);

        do_req(1, WR, 8'h00, 8'h00, 8'h01, 16'h0005, 16'h0000);
        do_req(2, WR, 8'h00, 8'h00, 8'h02, 16'h0007, 16'h0000);
        do_req(3, ADD, 8'h01, 8'h02, 8'h03, 16'h0000, 16'h0000);
        do_req(0, RD, 8'h03, 8'h00, 8'h00, 16'h0000, 16'h000C);
        do_req(1, SUB, 8'h01, 8'h02, 8'h04, 16'h0000, 16'h0000);
        do_req(2, RD, 8'h04, 8'h00, 8'h00, 16'h0000, 16'hFFFE);

        // Mixed stream across clients, including an overflowing ADD.
        do_req(1, WR, 8'h00, 8'h00, 8'h40, 16'h8000, 16'h0000);
        do_req(3, WR, 8'h00, 8'h00, 8'h41, 16'h8001, 16'h0000);
        do_req(1, ADD, 8'h40, 8'h41, 8'h42, 16'h0000, 16'h0000);
        do_req(3, RD, 8'h42, 8'h00, 8'h00, 16'h0000, 16'h0001);
        do_req(1, SUB, 8'h41, 8'h40, 8'h43, 16'h0000, 16'h0000);
        do_req(3, RD, 8'h43, 8'h00, 8'h00, 16'h0000, 16'h0001);
        do_req(0, RD, 8'h40, 8'h00, 8'h00, 16'h0000, 16'h8000);

        // Reset lands in the ISSUE cycle of a WR to 0x20: the write and response are dropped.
        @(negedge clk);
        req_valid[0] = 1'b1; req_cmd[1:0] = WR; req_addC[7:0] = 8'h20; req_wdata[15:0] = 16'hBEEF;
        #1;
        check("rst_wr_grant", {28'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_wr_issue", {30'd0, cs_cmd}, {30'd0, WR});
        reset = 1'b0;
        #1;
        check("rst_mid_bus", {6'd0, cs_cmd, cs_addA, cs_addB, cs_addC}, 32'd0);
        check("rst_mid_rsp", {11'd0, busy, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_mid_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_hold_rsp", {28'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_after_rsp", {27'd0, busy, rsp_valid}, 32'd0);
        do_req(0, RD, 8'h20, 8'h00, 8'h00, 16'h0000, 16'h0000);

        // Client 2 alone, twice in a row, so the second request arrives with the pointer on itself.
        do_req(2, RD, 8'h10, 8'h00, 8'h00, 16'h0000, 16'h1234);
        do_req(2, RD, 8'h03, 8'h00, 8'h00, 16'h0000, 16'h000C);
        @(negedge clk);
        check("final_idle", {27'd0, busy, rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
